dispatch_unit: RTL and testbench

//  Sits between the decoder and the reservation stations (ALU RS, LSB, branch RS).
//  Per accepted instruction it: allocates a ROB tag, renames rd in the register file,

---
 rtl/dispatch_unit_pkg.sv | 22 ++
 rtl/dispatch_unit_operand_resolve.sv | 65 ++++++
 rtl/dispatch_unit.sv | 198 +++++++++++++++++++
 tb/tb_dispatch_unit.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dispatch_unit_pkg.sv
// Shared definitions for the dispatch slice: default bus widths, the number of
// CDB buses, the null register index and the reservation-station unit codes.
// No ports.
package dispatch_unit_pkg;

   localparam int OP_W_DEF   = 6;
   localparam int TAG_W_DEF  = 4;
   localparam int DATA_W_DEF = 32;

   // CDB bus order: bit0 ALU, bit1 LSB, bit2 BR, bit3 ROB (lower index wins on a tag hit)
   localparam int NUM_CDB = 4;

   localparam logic [4:0] REG_NULL = 5'd0;

   typedef enum logic [1:0] {
      UNIT_ALU = 2'd0,
      UNIT_LSB = 2'd1,
      UNIT_BR  = 2'd2,
      UNIT_ILL = 2'd3
   } unit_e;

endpackage

// File: rtl/dispatch_unit_operand_resolve.sv
// Resolves one source operand: x0 -> regfile -> ROB -> same-cycle CDB hit.
// Ports:
//   rs                       architectural source register index
//   busy/rf_tag/rf_data      regfile read result (rf_tag = producing ROB tag)
//   rob_ready/rob_data       ROB probe result for rf_tag
//   cdb_valid/cdb_tag/cdb_data  packed CDB buses, slice k = bus k
//   valid/data/tag           resolved operand; tag meaningful only when not valid
// Forcing rs nonzero, busy high and rob_ready low turns this into a pure CDB
// tag matcher, which the top uses for the output-register bypass.
module dispatch_unit_operand_resolve
   import dispatch_unit_pkg::*;
#(
   parameter int TAG_W  = TAG_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic [4:0]                rs,
   input  logic                      busy,
   input  logic [TAG_W-1:0]          rf_tag,
   input  logic [DATA_W-1:0]         rf_data,
   input  logic                      rob_ready,
   input  logic [DATA_W-1:0]         rob_data,
   input  logic [NUM_CDB-1:0]        cdb_valid,
   input  logic [NUM_CDB*TAG_W-1:0]  cdb_tag,
   input  logic [NUM_CDB*DATA_W-1:0] cdb_data,
   output logic                      valid,
   output logic [DATA_W-1:0]         data,
   output logic [TAG_W-1:0]          tag
);

   logic              hit;
   logic [DATA_W-1:0] hit_data;

   // Scan from the highest bus down so the lowest-numbered matching bus wins.
   always_comb begin
      hit      = 1'b0;
      hit_data = '0;
      for (int k = NUM_CDB - 1; k >= 0; k--) begin
         if (cdb_valid[k] && (cdb_tag[k*TAG_W +: TAG_W] == rf_tag)) begin
            hit      = 1'b1;
            hit_data = cdb_data[k*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      valid = 1'b0;
      data  = '0;
      tag   = '0;
      if (rs == REG_NULL) begin
         valid = 1'b1;
      end else if (!busy) begin
         valid = 1'b1;
         data  = rf_data;
      end else if (rob_ready) begin
         valid = 1'b1;
         data  = rob_data;
      end else if (hit) begin
         valid = 1'b1;
         data  = hit_data;
      end else begin
         tag   = rf_tag;
      end
   end

endmodule

// File: rtl/dispatch_unit.sv
// Dispatch stage between the decoder and the reservation stations.
// Per accepted instruction: allocates a ROB tag, renames rd, resolves both
// operands and parks the packet in a one-entry output register that strobes
// the target RS on the following cycle.
// Ports:
//   clk, rst (sync, active high), rdy (global enable), clear (flush)
//   id_*          decoded instruction in; id_stall back to the decoder
//   rob_*         ROB allocation handshake and operand probes
//   rf_*          regfile read addresses/results and rename request
//   cdb_*         packed common data bus, bit0/slice0 = ALU
//   *_full        RS full flags; alurs/lsb/brs_valid one-hot dispatch strobes
//   ds_*          payload shared by all reservation stations
module dispatch_unit
   import dispatch_unit_pkg::*;
#(
   parameter int OP_W   = OP_W_DEF,
   parameter int TAG_W  = TAG_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      rdy,
   input  logic                      clear,
   input  logic                      id_valid,
   input  logic [1:0]                id_unit,
   input  logic [OP_W-1:0]           id_op,
   input  logic [4:0]                id_rd,
   input  logic [4:0]                id_rs1,
   input  logic [4:0]                id_rs2,
   input  logic [DATA_W-1:0]         id_imm,
   input  logic [DATA_W-1:0]         id_pc,
   output logic                      id_stall,
   input  logic                      rob_full,
   input  logic [TAG_W-1:0]          rob_alloc_tag,
   output logic                      rob_alloc_valid,
   output logic [OP_W-1:0]           rob_alloc_op,
   output logic [4:0]                rob_alloc_rd,
   output logic [DATA_W-1:0]         rob_alloc_pc,
   output logic [4:0]                rf_rs1_addr,
   output logic [4:0]                rf_rs2_addr,
   input  logic                      rf_rs1_busy,
   input  logic [TAG_W-1:0]          rf_rs1_tag,
   input  logic [DATA_W-1:0]         rf_rs1_data,
   input  logic                      rf_rs2_busy,
   input  logic [TAG_W-1:0]          rf_rs2_tag,
   input  logic [DATA_W-1:0]         rf_rs2_data,
   output logic [TAG_W-1:0]          rob_q1_tag,
   output logic [TAG_W-1:0]          rob_q2_tag,
   input  logic                      rob_q1_ready,
   input  logic [DATA_W-1:0]         rob_q1_data,
   input  logic                      rob_q2_ready,
   input  logic [DATA_W-1:0]         rob_q2_data,
   output logic                      rf_rename_valid,
   output logic [4:0]                rf_rename_rd,
   output logic [TAG_W-1:0]          rf_rename_tag,
   input  logic [NUM_CDB-1:0]        cdb_valid,
   input  logic [NUM_CDB*TAG_W-1:0]  cdb_tag,
   input  logic [NUM_CDB*DATA_W-1:0] cdb_data,
   input  logic                      alurs_full,
   input  logic                      lsb_full,
   input  logic                      brs_full,
   output logic                      alurs_valid,
   output logic                      lsb_valid,
   output logic                      brs_valid,
   output logic [OP_W-1:0]           ds_op,
   output logic [DATA_W-1:0]         ds_imm,
   output logic [DATA_W-1:0]         ds_pc,
   output logic [TAG_W-1:0]          ds_dest_tag,
   output logic                      ds_reg1_valid,
   output logic [DATA_W-1:0]         ds_reg1_data,
   output logic [TAG_W-1:0]          ds_reg1_tag,
   output logic                      ds_reg2_valid,
   output logic [DATA_W-1:0]         ds_reg2_data,
   output logic [TAG_W-1:0]          ds_reg2_tag
);

   logic              tgt_full, conflict, accept, fire;
   logic              r1_valid, r2_valid, byp1_valid, byp2_valid;
   logic [DATA_W-1:0] r1_data, r2_data, byp1_data, byp2_data;
   logic [TAG_W-1:0]  r1_tag, r2_tag, byp1_tag, byp2_tag;

   logic              st_valid;
   logic [1:0]        st_unit;
   logic [OP_W-1:0]   st_op;
   logic [DATA_W-1:0] st_imm, st_pc;
   logic [TAG_W-1:0]  st_dest;
   logic              st_r1_valid, st_r2_valid;
   logic [DATA_W-1:0] st_r1_data, st_r2_data;
   logic [TAG_W-1:0]  st_r1_tag, st_r2_tag;

   always_comb begin
      case (id_unit)
         UNIT_ALU: tgt_full = alurs_full;
         UNIT_LSB: tgt_full = lsb_full;
         UNIT_BR:  tgt_full = brs_full;
         default:  tgt_full = 1'b0;
      endcase
   end

   // The parked packet is not yet reflected in its RS full flag, so a second
   // instruction to the same RS has to wait one cycle.
   assign conflict = st_valid && (st_unit == id_unit);
   assign accept   = !rst && rdy && !clear && id_valid && (id_unit != UNIT_ILL)
                     && !rob_full && !tgt_full && !conflict;
   assign id_stall = id_valid && !accept;

   assign rob_alloc_valid = accept;
   assign rob_alloc_op    = accept ? id_op : '0;
   assign rob_alloc_rd    = accept ? id_rd : '0;
   assign rob_alloc_pc    = accept ? id_pc : '0;

   assign rf_rename_valid = accept && (id_rd != REG_NULL);
   assign rf_rename_rd    = rf_rename_valid ? id_rd : '0;
   assign rf_rename_tag   = rf_rename_valid ? rob_alloc_tag : '0;

   assign rf_rs1_addr = id_rs1;
   assign rf_rs2_addr = id_rs2;
   assign rob_q1_tag  = rf_rs1_tag;
   assign rob_q2_tag  = rf_rs2_tag;

   dispatch_unit_operand_resolve #(.TAG_W(TAG_W), .DATA_W(DATA_W)) u_res1 (
      .rs(id_rs1), .busy(rf_rs1_busy), .rf_tag(rf_rs1_tag), .rf_data(rf_rs1_data),
      .rob_ready(rob_q1_ready), .rob_data(rob_q1_data),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .valid(r1_valid), .data(r1_data), .tag(r1_tag));

   dispatch_unit_operand_resolve #(.TAG_W(TAG_W), .DATA_W(DATA_W)) u_res2 (
      .rs(id_rs2), .busy(rf_rs2_busy), .rf_tag(rf_rs2_tag), .rf_data(rf_rs2_data),
      .rob_ready(rob_q2_ready), .rob_data(rob_q2_data),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .valid(r2_valid), .data(r2_data), .tag(r2_tag));

   // Bypass matchers: nonzero rs, busy and no ROB data leave only the CDB path.
   dispatch_unit_operand_resolve #(.TAG_W(TAG_W), .DATA_W(DATA_W)) u_byp1 (
      .rs(5'd1), .busy(1'b1), .rf_tag(st_r1_tag), .rf_data('0),
      .rob_ready(1'b0), .rob_data('0),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .valid(byp1_valid), .data(byp1_data), .tag(byp1_tag));

   dispatch_unit_operand_resolve #(.TAG_W(TAG_W), .DATA_W(DATA_W)) u_byp2 (
      .rs(5'd1), .busy(1'b1), .rf_tag(st_r2_tag), .rf_data('0),
      .rob_ready(1'b0), .rob_data('0),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .valid(byp2_valid), .data(byp2_data), .tag(byp2_tag));

   assign fire        = st_valid && rdy && !clear && !rst;
   assign alurs_valid = fire && (st_unit == UNIT_ALU);
   assign lsb_valid   = fire && (st_unit == UNIT_LSB);
   assign brs_valid   = fire && (st_unit == UNIT_BR);

   assign ds_op         = st_op;
   assign ds_imm        = st_imm;
   assign ds_pc         = st_pc;
   assign ds_dest_tag   = st_dest;
   assign ds_reg1_valid = st_r1_valid || (st_valid && byp1_valid);
   assign ds_reg1_data  = st_r1_valid ? st_r1_data : (st_valid ? byp1_data : '0);
   assign ds_reg1_tag   = byp1_tag;
   assign ds_reg2_valid = st_r2_valid || (st_valid && byp2_valid);
   assign ds_reg2_data  = st_r2_valid ? st_r2_data : (st_valid ? byp2_data : '0);
   assign ds_reg2_tag   = byp2_tag;

   always_ff @(posedge clk) begin
      if (rst || clear || (rdy && !accept)) begin
         st_valid    <= 1'b0;
         st_unit     <= '0;
         st_op       <= '0;
         st_imm      <= '0;
         st_pc       <= '0;
         st_dest     <= '0;
         st_r1_valid <= 1'b0;
         st_r1_data  <= '0;
         st_r1_tag   <= '0;
         st_r2_valid <= 1'b0;
         st_r2_data  <= '0;
         st_r2_tag   <= '0;
      end else if (rdy) begin
         st_valid    <= 1'b1;
         st_unit     <= id_unit;
         st_op       <= id_op;
         st_imm      <= id_imm;
         st_pc       <= id_pc;
         st_dest     <= rob_alloc_tag;
         st_r1_valid <= r1_valid;
         st_r1_data  <= r1_data;
         st_r1_tag   <= r1_tag;
         st_r2_valid <= r2_valid;
         st_r2_data  <= r2_data;
         st_r2_tag   <= r2_tag;
      end else if (st_valid) begin
         // Frozen: keep the packet but capture any broadcast that resolves it.
         st_r1_valid <= ds_reg1_valid;
         st_r1_data  <= ds_reg1_data;
         st_r2_valid <= ds_reg2_valid;
         st_r2_data  <= ds_reg2_data;
      end
   end

endmodule

// File: tb/tb_dispatch_unit.sv
// Self-checking bench for dispatch_unit: a packet-level model checked every
// cycle, plus directed vectors with hand-computed expectations.
module tb_dispatch_unit;

   logic        clk = 1'b0;
   logic        rst, rdy, clear, id_valid;
   logic [1:0]  id_unit;
   logic [5:0]  id_op;
   logic [4:0]  id_rd, id_rs1, id_rs2;
   logic [31:0] id_imm, id_pc;
   logic        id_stall, rob_full, rob_alloc_valid;
   logic [3:0]  rob_alloc_tag;
   logic [5:0]  rob_alloc_op;
   logic [4:0]  rob_alloc_rd, rf_rs1_addr, rf_rs2_addr, rf_rename_rd;
   logic [31:0] rob_alloc_pc;
   logic        rf_rs1_busy, rf_rs2_busy, rob_q1_ready, rob_q2_ready, rf_rename_valid;
   logic [3:0]  rf_rs1_tag, rf_rs2_tag, rob_q1_tag, rob_q2_tag, rf_rename_tag;
   logic [31:0] rf_rs1_data, rf_rs2_data, rob_q1_data, rob_q2_data;
   logic [3:0]  cdb_valid;
   logic [15:0] cdb_tag;
   logic [127:0] cdb_data;
   logic        alurs_full, lsb_full, brs_full, alurs_valid, lsb_valid, brs_valid;
   logic [5:0]  ds_op;
   logic [31:0] ds_imm, ds_pc, ds_reg1_data, ds_reg2_data;
   logic [3:0]  ds_dest_tag, ds_reg1_tag, ds_reg2_tag;
   logic        ds_reg1_valid, ds_reg2_valid;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   dispatch_unit dut (
      .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
      .id_valid(id_valid), .id_unit(id_unit), .id_op(id_op), .id_rd(id_rd),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_imm(id_imm), .id_pc(id_pc),
      .id_stall(id_stall), .rob_full(rob_full), .rob_alloc_tag(rob_alloc_tag),
      .rob_alloc_valid(rob_alloc_valid), .rob_alloc_op(rob_alloc_op),
      .rob_alloc_rd(rob_alloc_rd), .rob_alloc_pc(rob_alloc_pc),
      .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
      .rf_rs1_busy(rf_rs1_busy), .rf_rs1_tag(rf_rs1_tag), .rf_rs1_data(rf_rs1_data),
      .rf_rs2_busy(rf_rs2_busy), .rf_rs2_tag(rf_rs2_tag), .rf_rs2_data(rf_rs2_data),
      .rob_q1_tag(rob_q1_tag), .rob_q2_tag(rob_q2_tag),
      .rob_q1_ready(rob_q1_ready), .rob_q1_data(rob_q1_data),
      .rob_q2_ready(rob_q2_ready), .rob_q2_data(rob_q2_data),
      .rf_rename_valid(rf_rename_valid), .rf_rename_rd(rf_rename_rd),
      .rf_rename_tag(rf_rename_tag),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .alurs_full(alurs_full), .lsb_full(lsb_full), .brs_full(brs_full),
      .alurs_valid(alurs_valid), .lsb_valid(lsb_valid), .brs_valid(brs_valid),
      .ds_op(ds_op), .ds_imm(ds_imm), .ds_pc(ds_pc), .ds_dest_tag(ds_dest_tag),
      .ds_reg1_valid(ds_reg1_valid), .ds_reg1_data(ds_reg1_data), .ds_reg1_tag(ds_reg1_tag),
      .ds_reg2_valid(ds_reg2_valid), .ds_reg2_data(ds_reg2_data), .ds_reg2_tag(ds_reg2_tag));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic        v;
      logic [31:0] d;
      logic [3:0]  t;
   } opnd_t;

   typedef struct packed {
      logic        v;
      logic [1:0]  unit;
      logic [5:0]  op;
      logic [31:0] imm;
      logic [31:0] pc;
      logic [3:0]  dest;
      opnd_t       o1;
      opnd_t       o2;
   } pkt_t;

   pkt_t pend = '0;
   pkt_t nxt  = '0;
   bit   started = 1'b0;

   // First CDB bus in ALU, LSB, BR, ROB order carrying tag t.
   function automatic logic [32:0] cdb_find(input logic [3:0] t);
      for (int k = 0; k < 4; k++)
         if (cdb_valid[k] && cdb_tag[k*4 +: 4] == t) return {1'b1, cdb_data[k*32 +: 32]};
      return 33'd0;
   endfunction

   function automatic opnd_t resolve(input logic [4:0] rs, input logic busy,
                                     input logic [3:0] t, input logic [31:0] d,
                                     input logic rr, input logic [31:0] rd_);
      opnd_t o;
      logic [32:0] h;
      o = '0;
      h = cdb_find(t);
      if (rs == 0)       o.v = 1'b1;
      else if (!busy)    begin o.v = 1'b1; o.d = d; end
      else if (rr)       begin o.v = 1'b1; o.d = rd_; end
      else if (h[32])    begin o.v = 1'b1; o.d = h[31:0]; end
      else               o.t = t;
      return o;
   endfunction

   function automatic opnd_t bypass(input opnd_t o);
      opnd_t r;
      logic [32:0] h;
      r = o;
      h = cdb_find(o.t);
      if (!o.v && h[32]) begin r.v = 1'b1; r.d = h[31:0]; end
      return r;
   endfunction

   always @(negedge clk) begin
      if (started) begin
         logic  tf, conf, acc;
         logic  [2:0] exs;
         opnd_t b1, b2;
         tf   = (id_unit == 2'd0) ? alurs_full : (id_unit == 2'd1) ? lsb_full :
                (id_unit == 2'd2) ? brs_full : 1'b0;
         conf = pend.v && pend.unit == id_unit;
         acc  = !rst && rdy && !clear && id_valid && id_unit != 2'd3 && !rob_full && !tf && !conf;
         chk("m_id_stall", id_stall, id_valid && !acc);
         chk("m_rob_alloc_valid", rob_alloc_valid, acc);
         chk("m_rename_valid", rf_rename_valid, acc && id_rd != 0);
         if (acc && id_rd != 0) chk("m_rename_tag", rf_rename_tag, rob_alloc_tag);
         if (acc) chk("m_rob_alloc_pc", rob_alloc_pc, id_pc);
         for (int u = 0; u < 3; u++) exs[u] = !rst && rdy && !clear && pend.v && pend.unit == u;
         chk("m_alurs_valid", alurs_valid, exs[0]);
         chk("m_lsb_valid", lsb_valid, exs[1]);
         chk("m_brs_valid", brs_valid, exs[2]);
         b1 = bypass(pend.o1);
         b2 = bypass(pend.o2);
         if (exs != 3'b000) begin
            chk("m_ds_op", ds_op, pend.op);
            chk("m_ds_imm", ds_imm, pend.imm);
            chk("m_ds_pc", ds_pc, pend.pc);
            chk("m_ds_dest", ds_dest_tag, pend.dest);
            chk("m_reg1_valid", ds_reg1_valid, b1.v);
            if (b1.v) chk("m_reg1_data", ds_reg1_data, b1.d); else chk("m_reg1_tag", ds_reg1_tag, b1.t);
            chk("m_reg2_valid", ds_reg2_valid, b2.v);
            if (b2.v) chk("m_reg2_data", ds_reg2_data, b2.d); else chk("m_reg2_tag", ds_reg2_tag, b2.t);
         end
         if (rst || clear) nxt = '0;
         else if (rdy) begin
            nxt = '0;
            if (acc) begin
               nxt.v = 1'b1; nxt.unit = id_unit; nxt.op = id_op; nxt.imm = id_imm;
               nxt.pc = id_pc; nxt.dest = rob_alloc_tag;
               nxt.o1 = resolve(id_rs1, rf_rs1_busy, rf_rs1_tag, rf_rs1_data, rob_q1_ready, rob_q1_data);
               nxt.o2 = resolve(id_rs2, rf_rs2_busy, rf_rs2_tag, rf_rs2_data, rob_q2_ready, rob_q2_data);
            end
         end else begin
            nxt = pend;
            if (pend.v) begin nxt.o1 = b1; nxt.o2 = b2; end
         end
      end
   end

   always @(posedge clk) begin
      pend    <= started ? nxt : '0;
      started <= 1'b1;
   end

   // ---------------- directed stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      rdy = 1'b1; clear = 1'b0; id_valid = 1'b0; id_unit = 2'd0; id_op = '0;
      id_rd = '0; id_rs1 = '0; id_rs2 = '0; id_imm = '0; id_pc = '0;
      rob_full = 1'b0; rob_alloc_tag = '0;
      rf_rs1_busy = 1'b0; rf_rs1_tag = '0; rf_rs1_data = '0;
      rf_rs2_busy = 1'b0; rf_rs2_tag = '0; rf_rs2_data = '0;
      rob_q1_ready = 1'b0; rob_q1_data = '0; rob_q2_ready = 1'b0; rob_q2_data = '0;
      cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
      alurs_full = 1'b0; lsb_full = 1'b0; brs_full = 1'b0;
   endtask

   task automatic issue(input logic [1:0] u, input logic [5:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] tag);
      id_valid = 1'b1; id_unit = u; id_op = op; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
      id_imm = imm; id_pc = pc; rob_alloc_tag = tag;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      quiet();
      rst = 1'b1;
      issue(2'd0, 6'h01, 5'd1, 5'd0, 5'd0, 32'h0, 32'h0, 4'd1);
      // 1. reset for two cycles with an instruction presented
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("rst_alurs", alurs_valid, 0);
         chk("rst_lsb", lsb_valid, 0);
         chk("rst_brs", brs_valid, 0);
         chk("rst_alloc", rob_alloc_valid, 0);
         chk("rst_stall", id_stall, 1);
         chk("rst_ds_reg1_valid", ds_reg1_valid, 0);
      end
      step(); rst = 1'b0;

      // 2. ALU, x1 ready = 5, rs2 = x0
      quiet(); issue(2'd0, 6'h0A, 5'd5, 5'd1, 5'd0, 32'h10, 32'h100, 4'd2); rf_rs1_data = 32'd5;
      @(negedge clk);
      chk("t2_alloc", rob_alloc_valid, 1);
      chk("t2_rename", rf_rename_valid, 1);
      chk("t2_rename_tag", rf_rename_tag, 2);
      chk("t2_stall", id_stall, 0);
      step(); quiet();
      @(negedge clk);
      chk("t2_alurs", alurs_valid, 1);
      chk("t2_reg1_valid", ds_reg1_valid, 1);
      chk("t2_reg1_data", ds_reg1_data, 5);
      chk("t2_reg2_valid", ds_reg2_valid, 1);
      chk("t2_reg2_data", ds_reg2_data, 0);
      chk("t2_dest", ds_dest_tag, 2);
      chk("t2_op", ds_op, 6'h0A);

      // 3. rs1 busy tag 3, resolved by same-cycle ALU CDB
      step(); quiet(); issue(2'd0, 6'h0B, 5'd6, 5'd3, 5'd0, 32'h0, 32'h104, 4'd5);
      rf_rs1_busy = 1'b1; rf_rs1_tag = 4'd3;
      cdb_valid = 4'b0001; cdb_tag[3:0] = 4'd3; cdb_data[31:0] = 32'h77;
      @(negedge clk);
      chk("t3_alloc", rob_alloc_valid, 1);
      step(); quiet();
      @(negedge clk);
      chk("t3_alurs", alurs_valid, 1);
      chk("t3_reg1_valid", ds_reg1_valid, 1);
      chk("t3_reg1_data", ds_reg1_data, 32'h77);

      // 4. LSB, rs1 tag 4 pending (LSB CDB in strobe cycle), rs2 tag 6 stays pending
      step(); quiet(); issue(2'd1, 6'h03, 5'd7, 5'd4, 5'd6, 32'h8, 32'h108, 4'd6);
      rf_rs1_busy = 1'b1; rf_rs1_tag = 4'd4; rf_rs2_busy = 1'b1; rf_rs2_tag = 4'd6;
      @(negedge clk);
      chk("t4_stall", id_stall, 0);
      step(); quiet();
      cdb_valid = 4'b0010; cdb_tag[7:4] = 4'd4; cdb_data[63:32] = 32'h9;
      @(negedge clk);
      chk("t4_lsb", lsb_valid, 1);
      chk("t4_reg1_valid", ds_reg1_valid, 1);
      chk("t4_reg1_data", ds_reg1_data, 32'h9);
      chk("t4_reg2_valid", ds_reg2_valid, 0);
      chk("t4_reg2_tag", ds_reg2_tag, 6);
      chk("t4_imm", ds_imm, 32'h8);

      // 5. back-to-back LSB: conflict stall, then lsb_full stall
      step(); quiet(); issue(2'd1, 6'h04, 5'd8, 5'd0, 5'd0, 32'h0, 32'h10C, 4'd7);
      @(negedge clk);
      chk("t5a_stall", id_stall, 0);
      step(); quiet(); issue(2'd1, 6'h05, 5'd9, 5'd0, 5'd0, 32'h0, 32'h110, 4'd8);
      @(negedge clk);
      chk("t5b_stall", id_stall, 1);
      chk("t5b_alloc", rob_alloc_valid, 0);
      chk("t5b_lsb", lsb_valid, 1);
      step();
      @(negedge clk);
      chk("t5c_stall", id_stall, 0);
      chk("t5c_alloc", rob_alloc_valid, 1);
      chk("t5c_lsb", lsb_valid, 0);
      step(); quiet(); lsb_full = 1'b1; issue(2'd1, 6'h06, 5'd9, 5'd0, 5'd0, 32'h0, 32'h114, 4'd9);
      @(negedge clk);
      chk("t5d_lsb", lsb_valid, 1);
      chk("t5d_stall", id_stall, 1);
      chk("t5d_alloc", rob_alloc_valid, 0);
      step(); quiet();
      @(negedge clk);
      chk("t5e_lsb", lsb_valid, 0);

      // illegal unit and rd = x0
      step(); quiet(); issue(2'd3, 6'h07, 5'd3, 5'd0, 5'd0, 32'h0, 32'h118, 4'd10);
      @(negedge clk);
      chk("ill_stall", id_stall, 1);
      chk("ill_alloc", rob_alloc_valid, 0);
      step(); quiet(); issue(2'd2, 6'h09, 5'd0, 5'd0, 5'd0, 32'h4, 32'h11C, 4'd10);
      @(negedge clk);
      chk("rd0_alloc", rob_alloc_valid, 1);
      chk("rd0_rename", rf_rename_valid, 0);
      step(); quiet();
      @(negedge clk);
      chk("rd0_brs", brs_valid, 1);

      // 6. clear kills the parked packet and any new allocation
      step(); quiet(); issue(2'd0, 6'h06, 5'd10, 5'd0, 5'd0, 32'h0, 32'h120, 4'd11);
      @(negedge clk);
      chk("t6a_alloc", rob_alloc_valid, 1);
      step(); quiet(); clear = 1'b1; issue(2'd2, 6'h07, 5'd7, 5'd0, 5'd0, 32'h0, 32'h124, 4'd12);
      @(negedge clk);
      chk("t6b_alurs", alurs_valid, 0);
      chk("t6b_rename", rf_rename_valid, 0);
      chk("t6b_alloc", rob_alloc_valid, 0);
      chk("t6b_stall", id_stall, 1);
      step(); quiet();
      @(negedge clk);
      chk("t6c_alurs", alurs_valid, 0);
      // rdy low freezes: no strobe, no allocation, packet survives
      step(); quiet(); issue(2'd0, 6'h08, 5'd11, 5'd0, 5'd0, 32'h0, 32'h128, 4'd13);
      @(negedge clk);
      chk("t6d_alloc", rob_alloc_valid, 1);
      step(); quiet(); rdy = 1'b0; issue(2'd2, 6'h0C, 5'd12, 5'd0, 5'd0, 32'h0, 32'h12C, 4'd14);
      @(negedge clk);
      chk("t6e_alurs", alurs_valid, 0);
      chk("t6e_alloc", rob_alloc_valid, 0);
      chk("t6e_rename", rf_rename_valid, 0);
      step(); quiet();
      @(negedge clk);
      chk("t6f_alurs", alurs_valid, 1);
      chk("t6f_op", ds_op, 6'h08);
      step(); quiet();
      @(negedge clk);
      chk("t6g_alurs", alurs_valid, 0);

      step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
